inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 29 ++
 rtl/inst_fetch.sv | 147 ++++++++++++++
 tb/tb_inst_fetch.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// inst_fetch_if -- bundle of the fetch unit's memory, decode and redirect
// signals.
//   master : the fetch unit
//            drives    imem_req/imem_addr, inst_valid/inst/inst_pc, fetch_err
//            receives  imem_rvalid/imem_rdata, inst_ready, redirect_valid/redirect_pc
//   slave  : the surrounding memory / decode / branch logic (mirror image)
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
    input  imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
    output imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch -- instruction fetch unit.
// Issues word fetches to instruction memory (at most one outstanding),
// buffers responses in a 2-entry {pc, inst} FIFO and presents the FIFO head
// to decode. A redirect flushes the FIFO and restarts fetch at redirect_pc;
// a response still in flight at that point is dropped in DRAIN.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - inst_fetch_if.master (memory request/response, decode handshake,
//          redirect, fetch_err)
// Parameter:
//   RESET_PC - first fetch address after reset
// Build option:
//   FETCH_ALIGN_CHECK_EN - when defined, a misaligned redirect sets fetch_err
//   and parks the unit in HALT until an aligned redirect; when undefined the
//   low two redirect bits are ignored and fetch_err is tied low.
//
// state | meaning
// IDLE  | one cycle after reset release
// FETCH | issuing requests, accepting responses into the FIFO
// DRAIN | waiting to drop the response of a request made before a redirect
// HALT  | misaligned redirect seen; no requests until an aligned redirect
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        outstanding_q, outstanding_d;
  logic [31:0] req_addr_q;
  logic [31:0] fifo_pc_q   [2];
  logic [31:0] fifo_inst_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;

  logic        redirect;
  logic        misaligned;
  logic [31:0] redir_target;
  logic        head_valid;
  logic        pop;
  logic        push;
  logic        req;
  logic [1:0]  occ_next;

  // Redirects are ignored during the single IDLE cycle.
  assign redirect = bus.redirect_valid && (state_q != IDLE);

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = bus.redirect_pc[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif
  assign redir_target = {bus.redirect_pc[31:2], bus.redirect_pc[1:0] & 2'b00};

  assign head_valid = count_q != 2'd0;
  assign pop        = head_valid && bus.inst_ready;
  // Entries that will be held once the outstanding response lands; pop only
  // asserts with a non-empty FIFO so this never underflows.
  assign occ_next   = count_q + {1'b0, outstanding_q} - {1'b0, pop};

  // In DRAIN the discarded response frees the memory slot, so the next
  // request goes out in the same cycle.
  assign req = !bus.redirect_valid &&
               ((state_q == FETCH) || (state_q == DRAIN && bus.imem_rvalid)) &&
               (!outstanding_q || bus.imem_rvalid) &&
               (occ_next < 2'd2);

  assign push = (state_q == FETCH) && !bus.redirect_valid &&
                bus.imem_rvalid && outstanding_q;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = req ? 1'b1 : (bus.imem_rvalid ? 1'b0 : outstanding_q);
    if (req) fetch_pc_d = fetch_pc_q + 32'd4;
    case (state_q)
      IDLE:    state_d = FETCH;
      DRAIN:   if (bus.imem_rvalid) state_d = FETCH;
      default: state_d = state_q;
    endcase
    if (redirect) begin
      fetch_pc_d = redir_target;
      if (misaligned)                              state_d = HALT;
      else if (outstanding_q && !bus.imem_rvalid)  state_d = DRAIN;
      else                                         state_d = FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      req_addr_q    <= 32'h0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      if (req) req_addr_q <= fetch_pc_q;
      if (redirect) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // FIFO payload needs no reset: it is only visible through head_valid.
  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      fifo_pc_q[wr_ptr_q]   <= req_addr_q;
      fifo_inst_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fetch_err_q <= 1'b0;
    else if (redirect) fetch_err_q <= misaligned;
  end
  assign bus.fetch_err = fetch_err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.imem_req   = req;
  assign bus.imem_addr  = req ? fetch_pc_q : 32'h0;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
  assign bus.inst_pc    = head_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: behavioural in-order memory with programmable
// latency, scoreboard of expected {pc, inst} transfers to decode, and
// directed checks around reset, stalls, redirects, wrap and alignment.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if bus_if ();

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t mq[$];

  typedef struct {logic [31:0] pc; logic [31:0] word;} exp_t;
  exp_t sbq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: responses driven at the falling edge, requests sampled 2 time
  // units later once the DUT's combinational request has settled.
  initial begin
    bus_if.imem_rvalid = 1'b0;
    bus_if.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mq.size() != 0 && mq[0].due == cyc) begin
        bus_if.imem_rvalid = 1'b1;
        bus_if.imem_rdata  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata  = 32'h0;
      end
      #2;
      if (rst) mq.delete();
      else if (bus_if.imem_req) mq.push_back('{bus_if.imem_addr, cyc + lat});
    end
  end

  // Monitor: a transfer is inst_valid & inst_ready without a redirect
  // overriding it in the same cycle.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && bus_if.inst_valid && bus_if.inst_ready && !bus_if.redirect_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer: got pc %h, expected no transfer", bus_if.inst_pc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (bus_if.inst_pc !== e.pc || bus_if.inst !== e.word) begin
            errors++;
            $display("FAIL xfer: got pc %h inst %h expected pc %h inst %h",
                     bus_if.inst_pc, bus_if.inst, e.pc, e.word);
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = start + 32'(4 * i);
      sbq.push_back('{pc, mem_word(pc)});
    end
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    bus_if.inst_ready = 1'b0;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d entries pending, expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  // Leaves the bench at the falling edge of the first cycle after release.
  task automatic do_reset(input int latency);
    step();
    rst = 1'b1;
    bus_if.inst_ready     = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    lat = latency;
    step(2);
    rst = 1'b0;
  endtask

  task automatic redirect_pulse(input logic [31:0] pc);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = pc;
  endtask

  initial begin
    bus_if.inst_ready     = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;

    // Reset values, with memory trying to respond while in reset.
    step(2);
    #3;
    chk("rst_imem_req",   {31'h0, bus_if.imem_req},   32'h0);
    chk("rst_imem_addr",  bus_if.imem_addr,           32'h0);
    chk("rst_inst_valid", {31'h0, bus_if.inst_valid}, 32'h0);
    chk("rst_inst",       bus_if.inst,                32'h0);
    chk("rst_inst_pc",    bus_if.inst_pc,             32'h0);
    chk("rst_fetch_err",  {31'h0, bus_if.fetch_err},  32'h0);

    // Streaming with 1-cycle memory: first valid 3 cycles after release,
    // then one instruction per cycle.
    do_reset(1);
    bus_if.inst_ready = 1'b1;
    expect_seq(32'h0, 8);
    #3;
    chk("idle_no_req", {31'h0, bus_if.imem_req}, 32'h0);
    step();
    #3;
    chk("first_req_addr", {bus_if.imem_addr[31:1], bus_if.imem_req}, 32'h1);
    step();
    #3;
    chk("valid_not_early", {31'h0, bus_if.inst_valid}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      #3;
      chk("stream_valid", {31'h0, bus_if.inst_valid}, 32'h1);
    end
    drain("stream", 20);

    // Decode stall: FIFO fills to 2, requests stop, head holds.
    do_reset(1);
    expect_seq(32'h0, 6);
    step(4);
    for (int i = 0; i < 6; i++) begin
      #3;
      chk("stall_req",   {31'h0, bus_if.imem_req},   32'h0);
      chk("stall_valid", {31'h0, bus_if.inst_valid}, 32'h1);
      chk("stall_pc",    bus_if.inst_pc,             32'h0);
      chk("stall_inst",  bus_if.inst,                mem_word(32'h0));
      step();
    end
    bus_if.inst_ready = 1'b1;
    drain("stall", 30);

    // 3-cycle memory, redirect while the first request is in flight.
    do_reset(3);
    bus_if.inst_ready = 1'b1;
    expect_seq(32'h100, 3);
    step(2);
    redirect_pulse(32'h100);
    #3;
    chk("redir_out_no_req", {31'h0, bus_if.imem_req}, 32'h0);
    step();
    bus_if.redirect_valid = 1'b0;
    step();
    #3;
    chk("drain_req", {31'h0, bus_if.imem_req}, 32'h1);
    chk("drain_addr", bus_if.imem_addr, 32'h100);
    drain("redir_out", 40);

    // Redirect in the same cycle as a response and a pop.
    do_reset(1);
    bus_if.inst_ready = 1'b1;
    expect_seq(32'h40, 4);
    step(3);
    #3;
    chk("pre_redir_valid",  {31'h0, bus_if.inst_valid},  32'h1);
    chk("pre_redir_rvalid", {31'h0, bus_if.imem_rvalid}, 32'h1);
    redirect_pulse(32'h40);
    step();
    bus_if.redirect_valid = 1'b0;
    #3;
    chk("flush_valid", {31'h0, bus_if.inst_valid}, 32'h0);
    chk("flush_req_addr", bus_if.imem_addr, 32'h40);
    step();
    #3;
    chk("flush_valid2", {31'h0, bus_if.inst_valid}, 32'h0);
    drain("redir_same", 20);

    // Fetch PC wrap at the top of the address space.
    do_reset(1);
    bus_if.inst_ready = 1'b1;
    expect_seq(32'hFFFF_FFF8, 4);
    step();
    redirect_pulse(32'hFFFF_FFF8);
    step();
    bus_if.redirect_valid = 1'b0;
    drain("wrap", 20);

    // Misaligned redirect.
    do_reset(1);
    bus_if.inst_ready = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    step();
    redirect_pulse(32'h102);
    step();
    bus_if.redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("halt_err",   {31'h0, bus_if.fetch_err},  32'h1);
      chk("halt_req",   {31'h0, bus_if.imem_req},   32'h0);
      chk("halt_valid", {31'h0, bus_if.inst_valid}, 32'h0);
      step();
    end
    expect_seq(32'h200, 3);
    redirect_pulse(32'h200);
    step();
    bus_if.redirect_valid = 1'b0;
    #3;
    chk("unhalt_err", {31'h0, bus_if.fetch_err}, 32'h0);
    chk("unhalt_addr", bus_if.imem_addr, 32'h200);
    drain("unhalt", 20);
`else
    expect_seq(32'h100, 3);
    step();
    redirect_pulse(32'h102);
    step();
    bus_if.redirect_valid = 1'b0;
    #3;
    chk("mask_err",  {31'h0, bus_if.fetch_err}, 32'h0);
    chk("mask_addr", bus_if.imem_addr,          32'h100);
    drain("mask", 20);
`endif

    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
